// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: round-robin arbiter of two register-write producers into a FIFO
// that drains one registered write per cycle toward the register-file decoder.
module wb_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_a_valid,
  input  logic [ADDR_W-1:0]          i_a_addr,
  input  logic [DATA_W-1:0]          i_a_data,
  output logic                       o_a_ready,
  input  logic                       i_b_valid,
  input  logic [ADDR_W-1:0]          i_b_addr,
  input  logic [DATA_W-1:0]          i_b_data,
  output logic                       o_b_ready,
  input  logic                       i_stall,
  output logic [ADDR_W-1:0]          o_writeaddress,
  output logic [DATA_W-1:0]          o_writedata,
  output logic                       o_wren,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_count;
  logic              r_last_b;
  logic              r_wren;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];

  logic w_full, w_grant_a, w_grant_b, w_push, w_pop;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign w_full    = r_count == CW'(DEPTH);
  assign w_grant_a = rst_n && !w_full && i_a_valid && (!i_b_valid || r_last_b);
  assign w_grant_b = rst_n && !w_full && i_b_valid && (!i_a_valid || !r_last_b);
  assign w_push    = w_grant_a || w_grant_b;
  assign w_pop     = (r_count != '0) && !i_stall;

  assign o_a_ready      = w_grant_a;
  assign o_b_ready      = w_grant_b;
  assign o_wren         = r_wren;
  assign o_writeaddress = r_waddr;
  assign o_writedata    = r_wdata;
  assign o_count        = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_last_b <= 1'b1;
      r_wren   <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_wr    <= r_wr + PW'(w_push);
      r_rd    <= r_rd + PW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_wren  <= w_pop;
      if (w_push) r_last_b <= w_grant_b;
      if (w_pop) begin
        r_waddr <= r_mem_addr[r_rd];
        r_wdata <= r_mem_data[r_rd];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr] <= w_grant_a ? i_a_addr : i_b_addr;
      r_mem_data[r_wr] <= w_grant_a ? i_a_data : i_b_data;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed bench with a scoreboard of accepted requests
// checked against each wren pulse.
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_a_valid = 1'b0, i_b_valid = 1'b0, i_stall = 1'b0;
  logic [2:0]  i_a_addr = '0, i_b_addr = '0;
  logic [15:0] i_a_data = '0, i_b_data = '0;
  logic        o_a_ready, o_b_ready, o_wren;
  logic [2:0]  o_writeaddress;
  logic [15:0] o_writedata;
  logic [2:0]  o_count;

  wb_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_a_valid(i_a_valid), .i_a_addr(i_a_addr), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_addr(i_b_addr), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .i_stall(i_stall), .o_writeaddress(o_writeaddress), .o_writedata(o_writedata),
    .o_wren(o_wren), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef logic [18:0] ent_t;
  ent_t sb[$];
  int   tests = 0, fails = 0, pops = 0;
  logic ga, gb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: record accepted requests before the edge, match any wren after it.
  task automatic tick;
    ent_t e;
    #1;
    ga = o_a_ready;
    gb = o_b_ready;
    if (ga) sb.push_back({i_a_addr, i_a_data});
    if (gb) sb.push_back({i_b_addr, i_b_data});
    @(posedge clk);
    #1;
    if (o_wren) begin
      pops++;
      chk("wren_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("writeaddress", 32'(o_writeaddress), 32'(e[18:16]));
        chk("writedata", 32'(o_writedata), 32'(e[15:0]));
      end
    end
    @(negedge clk);
  endtask

  task automatic drain;
    i_stall = 1'b0;
    for (int k = 0; k < 20 && (sb.size() != 0 || o_count != 0); k++) tick;
    chk("drain_count", 32'(o_count), 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    int na, nb, sent, p0;
    i_a_valid = 1'b1;
    #2;
    chk("rst_wren", 32'(o_wren), 0);
    chk("rst_waddr", 32'(o_writeaddress), 0);
    chk("rst_wdata", 32'(o_writedata), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_a_ready", 32'(o_a_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // tie arbitration, A first
    na = 0; nb = 0;
    i_a_valid = 1'b1; i_a_addr = 3'd0; i_a_data = 16'hA000;
    i_b_valid = 1'b1; i_b_addr = 3'd4; i_b_data = 16'hB000;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("tie_a_ready", 32'(ga), 32'(i % 2 == 0));
      chk("tie_b_ready", 32'(gb), 32'(i % 2 == 1));
      if (ga) begin
        na++; i_a_addr = 3'(na); i_a_data = 16'hA000 + 16'(na);
        if (na == 3) i_a_valid = 1'b0;
      end
      if (gb) begin
        nb++; i_b_addr = 3'(4 + nb); i_b_data = 16'hB000 + 16'(nb);
        if (nb == 3) i_b_valid = 1'b0;
      end
    end
    drain;
    // single write latency
    i_a_valid = 1'b1; i_a_addr = 3'd5; i_a_data = 16'h1234;
    tick;
    chk("single_accept", 32'(ga), 1);
    chk("single_wren_early", 32'(o_wren), 0);
    chk("single_count", 32'(o_count), 1);
    i_a_valid = 1'b0;
    tick;
    chk("single_wren", 32'(o_wren), 1);
    chk("single_addr", 32'(o_writeaddress), 5);
    chk("single_data", 32'(o_writedata), 32'h1234);
    tick;
    chk("single_wren_once", 32'(o_wren), 0);
    chk("single_count_end", 32'(o_count), 0);
    chk("single_hold_addr", 32'(o_writeaddress), 5);
    // full / backpressure
    i_stall = 1'b1; i_a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_a_addr = 3'(i + 1); i_a_data = 16'hC000 + 16'(i);
      tick;
      chk("full_fill_ready", 32'(ga), 1);
    end
    i_a_addr = 3'd7; i_a_data = 16'hC0FF;
    tick;
    chk("full_ready_low", 32'(ga), 0);
    chk("full_count", 32'(o_count), 4);
    chk("full_wren_stalled", 32'(o_wren), 0);
    i_stall = 1'b0;
    tick;
    chk("full_ready_still_low", 32'(ga), 0);
    chk("full_release_wren", 32'(o_wren), 1);
    tick;
    chk("full_ready_back", 32'(ga), 1);
    chk("full_release_wren", 32'(o_wren), 1);
    i_a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("full_release_wren", 32'(o_wren), 1);
    end
    tick;
    chk("full_done_wren", 32'(o_wren), 0);
    chk("full_done_count", 32'(o_count), 0);
    // simultaneous push and pop at count 2
    i_stall = 1'b1; i_a_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_a_addr = 3'(i + 1); i_a_data = 16'hD000 + 16'(i);
      tick;
    end
    chk("simul_pre_count", 32'(o_count), 2);
    i_stall = 1'b0; i_a_addr = 3'd3; i_a_data = 16'hD002;
    tick;
    chk("simul_push", 32'(ga), 1);
    chk("simul_count", 32'(o_count), 2);
    chk("simul_wren", 32'(o_wren), 1);
    i_a_valid = 1'b0;
    drain;
    // wrap-around stream from B with toggling stall
    sent = 0; p0 = pops;
    i_b_valid = 1'b1; i_b_addr = 3'd0; i_b_data = 16'h5000;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      i_stall = (c % 2) == 1;
      tick;
      if (gb) begin
        sent++; i_b_addr = 3'(sent); i_b_data = 16'h5000 + 16'(sent);
        if (sent == 10) i_b_valid = 1'b0;
      end
    end
    drain;
    chk("wrap_sent", 32'(sent), 10);
    chk("wrap_pops", 32'(pops - p0), 10);
    // asynchronous reset mid-drain
    i_stall = 1'b1; i_a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_a_addr = 3'(i + 1); i_a_data = 16'hE000 + 16'(i);
      tick;
    end
    i_a_valid = 1'b0; i_stall = 1'b0;
    tick;
    chk("mid_count", 32'(o_count), 3);
    chk("mid_wren", 32'(o_wren), 1);
    i_a_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wren", 32'(o_wren), 0);
    chk("arst_waddr", 32'(o_writeaddress), 0);
    chk("arst_wdata", 32'(o_writedata), 0);
    chk("arst_count", 32'(o_count), 0);
    chk("arst_a_ready", 32'(o_a_ready), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1; i_a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_no_wren", 32'(o_wren), 0);
      chk("post_rst_count", 32'(o_count), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
